// File: rtl/sevenseg_scan.sv
// Time-multiplexed 7-segment driver: per-digit hex/raw mode, PWM brightness,
// anti-ghost guard time and a double-buffered update applied at frame boundaries.
module sevenseg_scan #(
  parameter int DIGITS     = 3,
  parameter int CLK_DIV    = 1024,
  parameter int GUARD      = 16,
  parameter int BW_W       = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     raw,
  input  logic [DIGITS-1:0]     blank,
  input  logic [BW_W-1:0]       bright,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0]     GUARD_C  = CW'(GUARD);
  localparam logic [7:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  if (DIGITS < 1 || DIGITS > 8) begin : g_chk_digits
    $error("sevenseg_scan: DIGITS must be 1..8");
  end
  if ((CLK_DIV & (CLK_DIV - 1)) != 0 || CLK_DIV < (1 << BW_W)) begin : g_chk_div
    $error("sevenseg_scan: CLK_DIV must be a power of two >= 2**BW_W");
  end
  if (GUARD >= CLK_DIV) begin : g_chk_guard
    $error("sevenseg_scan: GUARD must be < CLK_DIV");
  end

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;

  logic [7:0]        pend_data [DIGITS];
  logic [DIGITS-1:0] pend_raw;
  logic [DIGITS-1:0] pend_blank;
  logic [BW_W-1:0]   pend_bright;
  logic              pend_valid;

  logic [7:0]        disp_data [DIGITS];
  logic [DIGITS-1:0] disp_raw;
  logic [DIGITS-1:0] disp_blank;
  logic [BW_W-1:0]   disp_bright;

  logic              boundary;
  logic [BW_W-1:0]   phase;
  logic [7:0]        cur_byte;
  logic              lit;
  logic [7:0]        seg_val;
  logic [DIGITS-1:0] onehot;

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  always_comb begin
    boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);
    phase    = cnt[CW-1 -: BW_W];
    cur_byte = disp_data[idx];
    lit      = (cnt >= GUARD_C) && (phase <= disp_bright) && !disp_blank[idx];
    seg_val  = disp_raw[idx] ? cur_byte : {cur_byte[7], hex_font(cur_byte[3:0])};
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      pend_raw    <= '0;
      pend_blank  <= '0;
      pend_bright <= '0;
      pend_valid  <= 1'b0;
      disp_raw    <= '0;
      disp_blank  <= '0;
      disp_bright <= '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        pend_data[i] <= '0;
        disp_data[i] <= '0;
      end
      seg         <= SEG_OFF;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      // A load on the boundary edge refills pending after the old contents move out.
      frame_start <= boundary && pend_valid;
      if (boundary && pend_valid) begin
        disp_data   <= pend_data;
        disp_raw    <= pend_raw;
        disp_blank  <= pend_blank;
        disp_bright <= pend_bright;
        pend_valid  <= 1'b0;
      end
      if (load) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          pend_data[i] <= data[8*i +: 8];
        end
        pend_raw    <= raw;
        pend_blank  <= blank;
        pend_bright <= bright;
        pend_valid  <= 1'b1;
      end

      if (lit) begin
        seg <= (ACTIVE_LOW != 0) ? ~seg_val : seg_val;
        an  <= (ACTIVE_LOW != 0) ? ~onehot  : onehot;
      end else begin
        seg <= SEG_OFF;
        an  <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: directed and random loads checked every cycle against
// an arithmetic model of the scan timing, buffering and font.
module tb_sevenseg_scan;
  localparam int DIGITS  = 3;
  localparam int CLK_DIV = 16;
  localparam int GUARD   = 2;
  localparam int BW_W    = 2;
  localparam int FRAME   = DIGITS * CLK_DIV;

  logic                clk = 1'b0;
  logic                rst;
  logic [8*DIGITS-1:0] data;
  logic [DIGITS-1:0]   raw;
  logic [DIGITS-1:0]   blank;
  logic [BW_W-1:0]     bright;
  logic                load;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_start;

  sevenseg_scan #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .GUARD(GUARD), .BW_W(BW_W), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .raw(raw), .blank(blank), .bright(bright),
    .load(load), .seg(seg), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc;
  int fs_count;

  logic [7:0]  font [16];
  logic [23:0] p_data, d_data;
  logic [2:0]  p_raw, d_raw, p_blank, d_blank;
  logic [1:0]  p_bright, d_bright;
  logic        p_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    p_data = '0; d_data = '0; p_raw = '0; d_raw = '0;
    p_blank = '0; d_blank = '0; p_bright = '0; d_bright = '0; p_valid = 1'b0;
  endtask

  // One clock: predict outputs from the pre-edge state, advance the model, compare.
  task automatic tick();
    int unsigned c, d;
    logic [7:0] b, v, e_seg;
    logic [2:0] e_an;
    logic e_fs;
    @(posedge clk);
    c = cyc % CLK_DIV;
    d = (cyc / CLK_DIV) % DIGITS;
    b = d_data[d*8 +: 8];
    v = d_raw[d] ? b : {b[7], font[b[3:0]][6:0]};
    if (c >= GUARD && (c / 4) <= d_bright && !d_blank[d]) begin
      e_seg = ~v;
      e_an  = ~(3'b001 << d);
    end else begin
      e_seg = 8'hFF;
      e_an  = 3'b111;
    end
    e_fs = 1'b0;
    if (cyc % FRAME == FRAME - 1 && p_valid) begin
      d_data = p_data; d_raw = p_raw; d_blank = p_blank; d_bright = p_bright;
      p_valid = 1'b0;
      e_fs = 1'b1;
    end
    if (load) begin
      p_data = data; p_raw = raw; p_blank = blank; p_bright = bright; p_valid = 1'b1;
    end
    cyc++;
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("an", 32'(an), 32'(e_an));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("onehot_an", 32'($countones(~an) <= 1), 32'(1));
    if (frame_start) fs_count++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [23:0] d, input logic [2:0] r, input logic [2:0] bl,
                         input logic [1:0] br);
    data = d; raw = r; blank = bl; bright = br; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_phase(input int unsigned ph);
    for (int i = 0; i < FRAME && (cyc % FRAME) != ph; i++) tick();
  endtask

  initial begin
    font = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    rst = 1'b0; data = '0; raw = '0; blank = '0; bright = '0; load = 1'b0;
    fs_count = 0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset_seg", 32'(seg), 32'h0FF);
    chk("reset_an", 32'(an), 32'h7);
    chk("reset_fs", 32'(frame_start), 32'h0);
    @(negedge clk) rst = 1'b0;
    model_reset();

    run(2 * FRAME);
    chk("no_load_no_pulse", 32'(fs_count), 32'h0);

    do_load(24'h050403, 3'b000, 3'b000, 2'd3);
    run(3 * FRAME);
    chk("one_pulse_after_load", 32'(fs_count), 32'h1);

    do_load(24'h000080, 3'b001, 3'b000, 2'd0);
    run(2 * FRAME);

    do_load(24'h0A0B0C, 3'b000, 3'b010, 2'd3);
    run(2 * FRAME);

    for (int k = 0; k < 6; k++) begin
      do_load(24'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)));
      run(FRAME + int'($urandom_range(FRAME, 2 * FRAME)));
    end

    wait_phase(10);
    do_load(24'h000001, 3'b000, 3'b000, 2'd3);
    run(5);
    do_load(24'h000002, 3'b000, 3'b000, 2'd3);
    run(2 * FRAME);

    wait_phase(FRAME - 1);
    do_load(24'h0E0D0C, 3'b000, 3'b000, 2'd2);
    fs_count = 0;
    run(FRAME + 2);
    chk("boundary_load_pulses", 32'(fs_count), 32'h1);

    do_load(24'h070707, 3'b000, 3'b000, 2'd3);
    run(FRAME + 10);
    wait_phase(CLK_DIV + 6);
    chk("digit1_lit", 32'(an), 32'h5);
    rst = 1'b1;
    #1;
    chk("async_rst_an", 32'(an), 32'h7);
    chk("async_rst_seg", 32'(seg), 32'h0FF);
    chk("async_rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk) rst = 1'b0;
    model_reset();
    fs_count = 0;
    run(2 * FRAME);
    chk("dark_after_reset", 32'(fs_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
